sdes_decrypt_core: RTL and testbench

Iterative S-DES decryption engine: accepts an 8-bit ciphertext and 10-bit key over a valid/ready handshake, derives subkeys K1/K2 internally (P10, LS-1, LS-2, P8), runs the two Feistel rounds in reverse key order (K2 then K1), and presents the 8-bit plaintext on a valid/ready output. It is the receive-side counterpart of the S-DES encrypt datapath in the DE1-SoC design, sitting between the ciphertext source (switches/UART) and the plaintext display logic.

---
 rtl/sdes_decrypt_core.sv | 183 ++++++++++++++++++
 tb/tb_sdes_decrypt_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdes_decrypt_core.sv
// ---------------------------------------------------------------------------
// sdes_decrypt_core
//
// Iterative S-DES decryption engine. A ciphertext byte and a 10-bit key are
// accepted over a valid/ready handshake. The engine derives the two subkeys
// itself, runs the two Feistel rounds in reverse key order (K2, then K1), and
// presents the plaintext on a valid/ready output. It is the receive-side
// counterpart of the S-DES encrypt datapath.
//
// The block takes five cycles when the downstream side never stalls:
//   IDLE -> KEYGEN -> ROUND1 -> ROUND2 -> DONE -> IDLE
//
// Bit numbering: S-DES bit 1 is the MSB of each vector, so table entry k
// selects vector bit (width - k).
//
// Ports
//   i_clk         in   1   system clock, rising edge
//   i_rst_n       in   1   asynchronous active-low reset
//   i_valid       in   1   ciphertext/key valid
//   o_ready       out  1   core can accept (high only in IDLE)
//   i_ciphertext  in   8   ciphertext, bit 7 = S-DES bit 1
//   i_key         in  10   key, bit 9 = S-DES bit 1
//   o_valid       out  1   plaintext valid (high only in DONE)
//   i_ready       in   1   downstream accepts plaintext
//   o_plaintext   out  8   decrypted byte, holds until the next ROUND2
// ---------------------------------------------------------------------------
module sdes_decrypt_core (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_ciphertext,
  input  logic [9:0] i_key,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_plaintext
);

  typedef enum logic [2:0] {
    IDLE,
    KEYGEN,
    ROUND1,
    ROUND2,
    DONE
  } state_t;

  // S-boxes are flattened row-major; index = {row, col} = {b1, b4, b2, b3}.
  localparam logic [1:0] S0_T [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1_T [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  // P10 = 3 5 2 7 4 10 1 9 8 6
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  // P8 = 6 3 7 4 8 5 10 9 (selects 8 of the 10 key-schedule bits)
  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  // Rotate both 5-bit halves left by one.
  function automatic logic [9:0] ls1(input logic [9:0] k);
    return {k[8:5], k[9], k[3:0], k[4]};
  endfunction

  // Rotate both 5-bit halves left by two.
  function automatic logic [9:0] ls2(input logic [9:0] k);
    return {k[7:5], k[9:8], k[2:0], k[4:3]};
  endfunction

  // IP = 2 6 3 1 4 8 5 7
  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  // IP^-1 = 4 1 3 5 7 2 8 6
  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  // EP = 4 1 2 3 2 3 4 1 on the right nibble
  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  // P4 = 2 4 3 1
  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // One Feistel round: left nibble is mixed, right nibble passes through.
  function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] sk);
    logic [7:0] t;
    logic [3:0] s;
    t = ep(d[3:0]) ^ sk;
    s = {S0_T[{t[7], t[4], t[6], t[5]}], S1_T[{t[3], t[0], t[2], t[1]}]};
    return {d[7:4] ^ p4(s), d[3:0]};
  endfunction

  state_t     state;
  logic [7:0] data_r;
  logic [9:0] key_r;
  logic [7:0] k1;
  logic [7:0] k2;

  // Key schedule and round datapaths are purely combinational off the
  // latched registers; the FSM decides which result is captured.
  logic [9:0] ks_shift1;
  logic [9:0] ks_shift3;
  logic [7:0] k1_next;
  logic [7:0] k2_next;
  logic [7:0] round_k2;
  logic [7:0] round_k1;

  assign ks_shift1 = ls1(p10(key_r));
  assign ks_shift3 = ls2(ks_shift1);
  assign k1_next   = p8(ks_shift1);
  assign k2_next   = p8(ks_shift3);
  assign round_k2  = fk(data_r, k2);
  assign round_k1  = fk(data_r, k1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_plaintext <= '0;
      data_r      <= '0;
      key_r       <= '0;
      k1          <= '0;
      k2          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            data_r  <= ip(i_ciphertext);
            key_r   <= i_key;
            o_ready <= 1'b0;
            state   <= KEYGEN;
          end
        end
        KEYGEN: begin
          k1    <= k1_next;
          k2    <= k2_next;
          state <= ROUND1;
        end
        ROUND1: begin
          // Decryption applies K2 first; the nibble swap follows round one.
          data_r <= {round_k2[3:0], round_k2[7:4]};
          state  <= ROUND2;
        end
        ROUND2: begin
          o_plaintext <= ip_inv(round_k1);
          o_valid     <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_sdes_decrypt_core
//
// Self-checking bench for sdes_decrypt_core. Expected plaintexts come from a
// table-driven S-DES model (generic permutation by table lookup) that
// encrypts a chosen plaintext; the DUT must decrypt back to it.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sdes_decrypt_core;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_ciphertext;
  logic [9:0] i_key;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_plaintext;

  sdes_decrypt_core dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_ciphertext (i_ciphertext),
    .i_key        (i_key),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_plaintext  (o_plaintext)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  localparam int IP_T  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  localparam int IPI_T [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  localparam int EP_T  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  localparam int P4_T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  localparam int S0_M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1_M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic int unsigned permute(input int unsigned v, input int n_in,
                                          input int n_out, input int t[10]);
    int unsigned r = 0;
    for (int i = 0; i < n_out; i++)
      r = (r << 1) | ((v >> (n_in - t[i])) & 1);
    return r;
  endfunction

  function automatic int unsigned rotl5(input int unsigned h, input int n);
    return ((h << n) | (h >> (5 - n))) & 31;
  endfunction

  function automatic void keysched(input int unsigned key, output int unsigned k1,
                                   output int unsigned k2);
    int unsigned p, l, r;
    p  = permute(key, 10, 10, P10_T);
    l  = rotl5(p >> 5, 1);
    r  = rotl5(p & 31, 1);
    k1 = permute((l << 5) | r, 10, 8, P8_T);
    l  = rotl5(l, 2);
    r  = rotl5(r, 2);
    k2 = permute((l << 5) | r, 10, 8, P8_T);
  endfunction

  function automatic int unsigned sbox(input int unsigned x, input bit which);
    int unsigned row, col;
    row = ((x >> 3) & 1) * 2 + (x & 1);
    col = ((x >> 2) & 1) * 2 + ((x >> 1) & 1);
    return which ? S1_M[row][col] : S0_M[row][col];
  endfunction

  function automatic int unsigned m_fk(input int unsigned v, input int unsigned k);
    int unsigned l, r, t, s;
    l = v >> 4;
    r = v & 15;
    t = permute(r, 4, 8, EP_T) ^ k;
    s = (sbox(t >> 4, 1'b0) << 2) | sbox(t & 15, 1'b1);
    l = l ^ permute(s, 4, 4, P4_T);
    return (l << 4) | r;
  endfunction

  function automatic logic [7:0] encrypt(input logic [7:0] pt, input logic [9:0] key);
    int unsigned k1, k2, v;
    keysched(key, k1, k2);
    v = permute(pt, 8, 8, IP_T);
    v = m_fk(v, k1);
    v = ((v & 15) << 4) | (v >> 4);
    v = m_fk(v, k2);
    return 8'(permute(v, 8, 8, IPI_T));
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full block with i_ready held high; caller is at a falling edge.
  task automatic xfer(input logic [9:0] key, input logic [7:0] ct,
                      input logic [7:0] exp, input string name);
    int n;
    i_key = key; i_ciphertext = ct; i_valid = 1'b1; i_ready = 1'b1;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge i_clk); n++; end
    chk({name, " accept"}, n < 20, 1);
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin @(negedge i_clk); n++; end
    chk({name, " latency"}, n, 3);
    chk({name, " plaintext"}, o_plaintext, exp);
    @(posedge i_clk); @(negedge i_clk);
    chk({name, " ready_after"}, {o_ready, o_valid}, 2'b10);
  endtask

  typedef struct {
    logic [9:0] key;
    logic [7:0] ct;
    logic [7:0] pt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] keys [7] = '{10'h000, 10'h3FF, 10'h155, 10'h2AA, 10'h001, 10'h200, 10'h0F3};
    logic [7:0] pts  [7] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h3C};
    logic [9:0] ka, kb;
    logic [7:0] pa, pb;
    int n, seen;

    vecs[0] = '{10'b1010000010, 8'b00111000, 8'b10010111};
    for (int i = 1; i < 8; i++)
      vecs[i] = '{keys[i-1], encrypt(pts[i-1], keys[i-1]), pts[i-1]};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_key = '0; i_ciphertext = '0;
    repeat (3) @(negedge i_clk);
    chk("reset state", {o_ready, o_valid, o_plaintext}, {1'b1, 1'b0, 8'h00});
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Known textbook vector, including the internal subkeys.
    xfer(vecs[0].key, vecs[0].ct, vecs[0].pt, "known");
    chk("known k1", dut.k1, 8'b10100100);
    chk("known k2", dut.k2, 8'b01000011);

    // Asynchronous reset while the block is in ROUND1.
    i_key = 10'h2C5; i_ciphertext = 8'h4E; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("pre-reset plaintext held", o_plaintext, 8'b10010111);
    i_rst_n = 1'b0;
    #1;
    chk("mid reset outputs", {o_valid, o_ready, o_plaintext}, {1'b0, 1'b1, 8'h00});
    chk("mid reset k1", dut.k1, 8'h00);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge i_clk); if (o_valid) seen++; end
    chk("no valid after reset", seen, 0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++)
      xfer(vecs[i].key, vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));

    // Inputs changing after the accept edge must not disturb the block.
    ka = 10'($urandom); pa = 8'($urandom);
    i_key = ka; i_ciphertext = encrypt(pa, ka); i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_key = 10'($urandom); i_ciphertext = 8'($urandom);
      @(negedge i_clk);
    end
    chk("late change valid", o_valid, 1'b1);
    chk("late change plaintext", o_plaintext, pa);
    @(posedge i_clk); @(negedge i_clk);

    // Backpressure: hold i_ready low for 20 cycles while a second block waits.
    ka = 10'($urandom); pa = 8'($urandom);
    kb = 10'($urandom); pb = 8'($urandom);
    i_ready = 1'b0;
    i_key = ka; i_ciphertext = encrypt(pa, ka); i_valid = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin @(negedge i_clk); n++; end
    chk("bp latency", n, 3);
    i_key = kb; i_ciphertext = encrypt(pb, kb); i_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk("bp hold", {o_valid, o_ready, o_plaintext}, {1'b1, 1'b0, pa});
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    chk("bp release", {o_ready, o_valid}, 2'b10);
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    chk("bp second accepted", o_ready, 1'b0);
    n = 0;
    while (!o_valid && n < 20) begin @(negedge i_clk); n++; end
    chk("bp second latency", n, 3);
    chk("bp second plaintext", o_plaintext, pb);
    @(posedge i_clk); @(negedge i_clk);

    // Back-to-back: i_valid held high across three blocks.
    begin
      logic [9:0] bk [3];
      logic [7:0] bp [3];
      int cyc, acc, outs, last_acc;
      bit will_acc;
      for (int i = 0; i < 3; i++) begin bk[i] = 10'($urandom); bp[i] = 8'($urandom); end
      i_ready = 1'b1;
      i_key = bk[0]; i_ciphertext = encrypt(bp[0], bk[0]); i_valid = 1'b1;
      cyc = 0; acc = 0; outs = 0; last_acc = 0;
      while (cyc < 60 && outs < 3) begin
        chk("b2b exclusive", o_ready & o_valid, 1'b0);
        will_acc = o_ready && i_valid;
        if (o_valid) begin
          chk($sformatf("b2b plaintext%0d", outs), o_plaintext, bp[outs]);
          outs++;
        end
        @(posedge i_clk); @(negedge i_clk);
        cyc++;
        if (will_acc) begin
          if (acc > 0) chk("b2b spacing", cyc - last_acc, 5);
          last_acc = cyc;
          acc++;
          if (acc < 3) begin
            i_key = bk[acc]; i_ciphertext = encrypt(bp[acc], bk[acc]);
          end else begin
            i_valid = 1'b0;
          end
        end
      end
      chk("b2b outputs", outs, 3);
      chk("b2b accepts", acc, 3);
    end

    // Round-trip sweep over every key with random plaintexts.
    for (int k = 0; k < 1024; k++) begin
      for (int j = 0; j < 4; j++) begin
        pa = 8'($urandom);
        xfer(10'(k), encrypt(pa, 10'(k)), pa, $sformatf("sweep k=%0d", k));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
